// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   funct3 encodings and access-size codes, FSM state enum, error enum,
//   default bus timeout, and decode helpers for illegal/misaligned accesses.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned LSU_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  // Stores only have signed-size encodings; loads reject 011/110/111.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    return we ? !(f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {3'b011, 3'b110, 3'b111});
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return (f3[1:0] == SZ_H && lo[0]) || (f3[1:0] == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: combinational lane formatting for the load/store unit.
//   i_funct3   access size/sign
//   i_addr_lo  byte offset within the word
//   i_st_data  store data (rs2)
//   i_rdata    bus read data
//   o_wdata    lane-replicated store data
//   o_be       byte enables (halfword uses addr[1] only, word ignores offset)
//   o_ld_data  lane-extracted, sign/zero-extended load data
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_ld_data
);
  logic [1:0]  w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size = i_funct3[1:0];
  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  assign o_wdata = (w_size == SZ_B) ? {4{i_st_data[7:0]}} :
                   (w_size == SZ_H) ? {2{i_st_data[15:0]}} : i_st_data;

  assign o_be = (w_size == SZ_B) ? (4'b0001 << i_addr_lo) :
                (w_size == SZ_H) ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) :
                (w_size == SZ_W) ? 4'b1111 : 4'b0000;

  assign o_ld_data = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
                     (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
                     (i_funct3 == F3_W)  ? i_rdata :
                     (i_funct3 == F3_BU) ? {24'd0, w_byte} :
                     (i_funct3 == F3_HU) ? {16'd0, w_half} : 32'd0;
endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit performing one data-memory access per request.
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_lsu_req/we/funct3   access request from execute (sampled in IDLE)
//   i_addr, i_st_data     effective byte address, store data
//   o_busy, o_done        stall while not IDLE, one-cycle completion pulse
//   o_ld_data, o_err      extended load result and error code, valid with o_done
//   o_mem_*/i_mem_*       req/gnt/rvalid data-memory bus
// Parameter TIMEOUT_CYC bounds the wait for gnt and, separately, for rvalid.
// Macro LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses finish with
// error 01 and no bus traffic; otherwise low address bits are force-aligned.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = LSU_TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic [1:0]  o_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e  r_state, w_next;
  lsu_err_e    r_err, w_err;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lo;
  logic [7:0]  r_timer;
  logic        r_busy, r_done, r_mem_req, r_mem_we;
  logic [31:0] r_ld_data, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        w_idle, w_accept, w_bad_f3, w_misal, w_timeout, w_rsp;
  logic [2:0]  w_f3;
  logic [1:0]  w_lo;
  logic [31:0] w_wdata, w_ld_ext, w_ld_data;
  logic [3:0]  w_be;

  assign w_idle   = r_state == S_IDLE;
  assign w_accept = w_idle && i_lsu_req;
  assign w_rsp    = r_state == S_WAIT && i_mem_rvalid;

  // One formatter serves both directions: store formatting is only needed
  // while accepting in IDLE, load extraction only on the WAIT response.
  assign w_f3 = w_idle ? i_funct3 : r_funct3;
  assign w_lo = w_idle ? i_addr[1:0] : r_lo;

  lsu_data_align u_align (
    .i_funct3  (w_f3),
    .i_addr_lo (w_lo),
    .i_st_data (i_st_data),
    .i_rdata   (i_mem_rdata),
    .o_wdata   (w_wdata),
    .o_be      (w_be),
    .o_ld_data (w_ld_ext)
  );

  assign w_bad_f3 = funct3_illegal(i_lsu_we, i_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misal = misaligned(i_funct3, i_addr[1:0]);
`else
  assign w_misal = 1'b0;
`endif
  assign w_timeout = r_timer == TMO_LAST;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_lsu_req) w_next = (w_bad_f3 || w_misal) ? S_DONE : S_REQ;
      S_REQ:   w_next = i_mem_gnt ? S_WAIT : (w_timeout ? S_DONE : S_REQ);
      S_WAIT:  w_next = (i_mem_rvalid || w_timeout) ? S_DONE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  // Error code is only consumed on the transition into DONE; a grant that
  // coincides with the last timer cycle wins over the timeout.
  always_comb begin
    w_err     = w_idle ? (w_bad_f3 ? ERR_ILLEGAL : ERR_MISALIGN) : (w_rsp ? ERR_NONE : ERR_TIMEOUT);
    w_ld_data = (w_rsp && !r_mem_we) ? w_ld_ext : 32'd0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_err       <= ERR_NONE;
      r_funct3    <= '0;
      r_lo        <= '0;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_ld_data   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_state   <= w_next;
      r_timer   <= (w_next == r_state && !w_idle) ? r_timer + 8'd1 : 8'd0;
      r_busy    <= w_next != S_IDLE;
      r_done    <= w_next == S_DONE;
      r_mem_req <= w_next == S_REQ;
      r_err     <= (w_next == S_DONE) ? w_err : ERR_NONE;
      r_ld_data <= (w_next == S_DONE) ? w_ld_data : 32'd0;
      if (w_accept) begin
        r_funct3    <= i_funct3;
        r_lo        <= i_addr[1:0];
        r_mem_we    <= i_lsu_we;
        r_mem_addr  <= {i_addr[31:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_be    <= w_be;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ld_data   = r_ld_data;
  assign o_err       = r_err;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a byte-lane reference model.
module tb_lsu;
  localparam int TMO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_lsu_req = 1'b0;
  logic        i_lsu_we = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_st_data = '0;
  logic        o_busy, o_done, o_mem_req, o_mem_we;
  logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata;
  logic [1:0]  o_err;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  int vecs = 0;
  int errs = 0;

  lsu #(.TIMEOUT_CYC(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_st_data(i_st_data),
    .o_busy(o_busy), .o_done(o_done), .o_ld_data(o_ld_data), .o_err(o_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, o_busy}, 0);
    chk({tag, "_done"}, {31'd0, o_done}, 0);
    chk({tag, "_err"}, {30'd0, o_err}, 0);
    chk({tag, "_ld"}, o_ld_data, 0);
    chk({tag, "_req"}, {31'd0, o_mem_req}, 0);
    chk({tag, "_we"}, {31'd0, o_mem_we}, 0);
    chk({tag, "_addr"}, o_mem_addr, 0);
    chk({tag, "_wdata"}, o_mem_wdata, 0);
    chk({tag, "_be"}, {28'd0, o_mem_be}, 0);
  endtask

  task automatic finish_chk(input string tag, input logic [1:0] e_err, input logic [31:0] e_ld);
    chk({tag, "_done"}, {31'd0, o_done}, 1);
    chk({tag, "_err"}, {30'd0, o_err}, {30'd0, e_err});
    chk({tag, "_ld"}, o_ld_data, e_ld);
    chk({tag, "_req"}, {31'd0, o_mem_req}, 0);
    @(negedge i_clk);
    chk({tag, "_idle"}, {30'd0, o_busy, o_done}, 0);
  endtask

  // Reference: an access touches sz bytes at the size-aligned offset within
  // the word; stores replicate the low sz bytes, loads shift and extend.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int g, input int r, input logic [31:0] rd);
    int sz, off;
    logic [31:0] e_be, e_wd, e_ld, mask;
    logic [1:0]  e_err;
    sz    = 1 << f3[1:0];
    off   = int'(a % 4) / sz * sz;
    e_err = (we ? f3 > 3'd2 : (f3[1:0] == 2'd3 || f3 > 3'd5)) ? 2'b11 : 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
    if (e_err == 2'b00 && (a % sz) != 0) e_err = 2'b01;
`endif
    mask = (sz >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    e_be = ((32'd1 << sz) - 32'd1) << off;
    e_wd = (sz == 1) ? sd[7:0] * 32'h0101_0101 : (sz == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    e_ld = (rd >> (8 * off)) & mask;
    if (!f3[2] && sz < 4 && e_ld[8 * sz - 1]) e_ld = e_ld | ~mask;
    if (we) e_ld = 32'd0;
    @(negedge i_clk);
    i_lsu_req = 1'b1; i_lsu_we = we; i_funct3 = f3; i_addr = a; i_st_data = sd;
    @(negedge i_clk);
    i_lsu_req = 1'b0; i_addr = $urandom; i_st_data = $urandom; i_funct3 = 3'($urandom);
    chk("busy", {31'd0, o_busy}, 1);
    if (e_err != 2'b00) begin
      finish_chk("early", e_err, 32'd0);
      return;
    end
    chk("addr", o_mem_addr, a & ~32'd3);
    chk("be", {28'd0, o_mem_be}, e_be);
    chk("we", {31'd0, o_mem_we}, {31'd0, we});
    if (we) chk("wdata", o_mem_wdata, e_wd);
    for (int k = 0; k < TMO; k++) begin
      chk("req_hold", {30'd0, o_mem_req, o_done}, 2);
      i_mem_gnt = (k == g);
      i_mem_rvalid = 1'($urandom);
      i_mem_rdata = $urandom;
      @(negedge i_clk);
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
      if (k == g) break;
    end
    if (g >= TMO) begin
      finish_chk("gnt_tmo", 2'b10, 32'd0);
      return;
    end
    for (int k = 0; k < TMO; k++) begin
      chk("wait", {30'd0, o_mem_req, o_done}, 0);
      i_mem_rvalid = (k == r);
      i_mem_rdata = (k == r) ? rd : $urandom;
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      if (k == r) break;
    end
    if (r >= TMO) begin
      finish_chk("rv_tmo", 2'b10, 32'd0);
      return;
    end
    finish_chk("fin", 2'b00, e_ld);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0);
    access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 32'h8011_2233);
    access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 2, 32'h8011_2233);
    access(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 2, 1, 32'h0);
    access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h1234_5678);
    access(1'b0, 3'b001, 32'h0000_0203, 32'h0, 0, 0, 32'h8001_7FFF);
    access(1'b0, 3'b101, 32'h0000_0206, 32'h0, 0, 0, 32'h8001_7FFF);
    access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 100, 0, 32'h0);
    access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 15, 0, 32'hCAFE_F00D);
    access(1'b1, 3'b000, 32'h0000_0301, 32'h0000_005A, 0, 100, 32'h0);
    access(1'b0, 3'b011, 32'h0000_0400, 32'h0, 0, 0, 32'h0);
    access(1'b1, 3'b100, 32'h0000_0400, 32'h1111_1111, 0, 0, 32'h0);
    // Reset asserted mid-access (WAIT) must clear every output without a clock edge.
    @(negedge i_clk);
    i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_0500; i_st_data = 32'h5555_AAAA;
    @(negedge i_clk);
    i_lsu_req = 1'b0; i_mem_gnt = 1'b1;
    @(negedge i_clk);
    i_mem_gnt = 1'b0;
    chk("in_wait", {30'd0, o_busy, o_mem_req}, 2);
    #2 i_rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int n = 0; n < 150; n++)
      access(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
             ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3)),
             ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3)), $urandom);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core: consumes the effective address produced by the `alu` (`o_alu_data`) plus store data and funct3, and performs one data-memory access over a req/gnt/rvalid bus. It handles byte-enable and lane alignment, misalignment detection, and load sign/zero extension. It stalls the core until the access completes. It sits between execute and writeback.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 16: maximum cycles spent waiting for gnt, and separately for rvalid, before a bus error is declared. Range 2..255.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_lsu_req`  in  1  start an access; sampled only in IDLE.
- `i_lsu_we`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  access size and sign: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- `i_addr`  in  32  effective byte address (ALU result).
- `i_st_data`  in  32  store data (rs2).
- `o_busy`  out  1  stall: high in every state other than IDLE.
- `o_done`  out  1  one-cycle pulse when the access finishes.
- `o_ld_data`  out  32  extended load result; valid while `o_done` is high.
- `o_err`  out  2  valid with `o_done`: 00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3.
- `o_mem_req`  out  1  bus request.
- `o_mem_we`  out  1  bus write.
- `o_mem_addr`  out  32  word-aligned address, with `[1:0]` = 00.
- `o_mem_wdata`  out  32  lane-replicated store data.
- `o_mem_be`  out  4  byte enables.
- `i_mem_gnt`  in  1  request accepted.
- `i_mem_rvalid`  in  1  response valid; acknowledges stores as well as loads.
- `i_mem_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `i_lsu_req` is high, latch we, funct3, addr, and the formatted wdata/be.
  - Illegal funct3 or misalignment goes directly to DONE with the matching error code. No bus access occurs.
  - Otherwise go to REQ.
- Illegal funct3 for loads: 011, 110, 111. For stores: anything other than 000, 001, 010.
- Misalignment rules: halfword with `addr[0]` = 1; word with `addr[1:0]` ≠ 00.
- REQ:
  - `o_mem_req` is held high with stable addr, we, wdata and be until `i_mem_gnt` is seen.
  - When gnt arrives, go to WAIT and reset the timer.
- WAIT:
  - On `i_mem_rvalid`, capture the extended data and go to DONE.
  - `i_mem_rvalid` seen in any state other than WAIT is ignored.
- DONE: assert `o_done` for exactly one cycle, then go to IDLE. `o_busy` is low in DONE-exit/IDLE.
- Timer: an 8-bit counter that increments in REQ and in WAIT. When it reaches `TIMEOUT_CYC`, go to DONE with `o_err` = 10 and drop `o_mem_req`.
- Store formatting:
  - SB: byte replicated across all 4 lanes; `be = 1 << addr[1:0]`.
  - SH: halfword replicated; `be` = 0011 or 1100, selected by `addr[1]`.
  - SW: `be` = 1111.
- Load extraction:
  - The lane is selected by the latched `addr[1:0]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- On any error, `o_ld_data` = 0.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0, including `o_mem_req`, `o_busy`, `o_done`, `o_err`, `o_ld_data`, `o_mem_be`, `o_mem_addr` and `o_mem_wdata`.
  - Asserting reset mid-access aborts immediately; `o_mem_req` falls asynchronously.
- Request at cycle N (IDLE):
  - `o_busy` is high from N+1.
  - `o_mem_req` is high at N+1.
- Best case: gnt at N+1, rvalid at N+2, `o_done` at N+3. Minimum latency is 3 cycles.
- Error detected at cycle N (illegal funct3 or misaligned): `o_done` at N+1.
- The earliest new request is the cycle after DONE.
- All outputs are registered. There are no combinational paths from bus inputs to core outputs.

## Configuration
- `LSU_MISALIGN_TRAP_EN`:
  - Defined: misaligned accesses end with `o_err` = 01 and make no bus access.
  - Undefined: misalignment is not checked. Low address bits are force-aligned to the access size (halfword ignores `addr[0]`; word ignores `addr[1:0]`), the access proceeds normally, and error code 01 is never produced.

## Structure
- Package `lsu_pkg` holds:
  - funct3 size constants;
  - state enum `lsu_state_e`;
  - error enum `lsu_err_e`;
  - the default timeout constant.
- Sub-module `lsu_data_align` (combinational) contains the store replicate/byte-enable logic and the load lane-extract/extend logic. The top level holds the FSM, timer and registers.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, gnt at N+1, rvalid at N+2:
  - bus shows `o_mem_addr` 0x100, `be` 1111, `o_mem_we` 1;
  - `o_done` at N+3 with `o_err` 00.
- LB from 0x103, rdata 0x80112233 → `o_ld_data` 0xFFFFFF80. LBU from the same address → 0x00000080.
- SH to 0x102 with data 0x0000ABCD → `o_mem_wdata` 0xABCDABCD, `be` 1100.
- LW from 0x101:
  - with the macro: `o_done` at N+1, `o_err` 01, no `o_mem_req`;
  - without the macro: bus address 0x100, normal completion.
- Gnt withheld with `TIMEOUT_CYC` = 16 → `o_err` 10 after 16 REQ cycles and `o_mem_req` drops. A separate run that asserts reset in WAIT returns all outputs to 0 immediately.
- funct3 011 load, and funct3 100 store → `o_err` 11 at N+1, no bus activity.
